iq_multi_demod: RTL

Parametrised successor to the fixed-LO AM/FM demodulation chain. Accepts baseband I/Q samples with a valid strobe and runs an iterative CORDIC in vectoring mode to get magnitude and phase. Produces AM (magnitude), PM (phase) or FM (phase difference) output, selectable at run time. A programmable power-of-two averaging decimator sits on the output. Sits after the I/Q down-converter and feeds the audio path.

---
 rtl/demod_pkg.sv | 56 +++++
 rtl/cordic_vector_iter.sv | 95 +++++++++
 rtl/iq_multi_demod.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/demod_pkg.sv
// Shared definitions for the I/Q multi-mode demodulator.
//   - output mode encodings
//   - top-level FSM state enum
//   - CORDIC arctangent constants scaled so that +/-2^(phase_width-1) is +/-pi
//   - CORDIC vectoring gain (not compensated in the datapath)
package demod_pkg;

    localparam logic [1:0] MODE_AM   = 2'b00;
    localparam logic [1:0] MODE_FM   = 2'b01;
    localparam logic [1:0] MODE_PM   = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ROT  = 3'd2,
        ST_POST = 3'd3,
        ST_ACC  = 3'd4
    } demod_state_e;

    // Product of 1/cos(atan(2^-i)) over the iterations, in Q12 (~1.6468).
    localparam int CORDIC_GAIN_Q12 = 6745;

    // round(atan(2^-i) * 2^15 / pi): angle table for a 16-bit phase word.
    function automatic int atan_tbl16(input int i);
        case (i)
            0:       return 8192;
            1:       return 4836;
            2:       return 2555;
            3:       return 1297;
            4:       return 651;
            5:       return 326;
            6:       return 163;
            7:       return 81;
            8:       return 41;
            9:       return 20;
            10:      return 10;
            11:      return 5;
            12:      return 3;
            13:      return 1;
            14:      return 1;
            default: return 0;
        endcase
    endfunction

    // Rescale the 16-bit table to the requested phase width (rounded).
    function automatic int atan_const(input int i, input int phase_width);
        int v;
        v = atan_tbl16(i);
        if (phase_width >= 16) begin
            return v <<< (phase_width - 16);
        end
        return (v + (1 <<< (15 - phase_width))) >>> (16 - phase_width);
    endfunction

endpackage

// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC in vectoring mode.
//   load      : capture i_in/q_in (sign-extended by two guard bits)
//   pre_en    : one cycle of quadrant fold into the right half-plane
//   rot_en    : one micro-rotation per cycle; done flags the last one
//   magnitude : final x (unsigned, carries the CORDIC gain)
//   phase     : accumulated angle, +/-2^(PHASE_WIDTH-1) = +/-pi; 0 for a zero vector
module cordic_vector_iter
    import demod_pkg::*;
#(
    parameter int IQ_WIDTH    = 12,
    parameter int PHASE_WIDTH = 16,
    parameter int CORDIC_ITER = 12
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   pre_en,
    input  logic                   rot_en,
    input  logic [IQ_WIDTH-1:0]    i_in,
    input  logic [IQ_WIDTH-1:0]    q_in,
    output logic                   done,
    output logic [IQ_WIDTH+1:0]    magnitude,
    output logic [PHASE_WIDTH-1:0] phase
);

    localparam int XY_W = IQ_WIDTH + 2;
    localparam int IT_W = (CORDIC_ITER > 1) ? $clog2(CORDIC_ITER) : 1;

    logic signed [XY_W-1:0]  x_q, x_d, y_q, y_d;
    logic signed [XY_W-1:0]  x_sh, y_sh;
    logic [PHASE_WIDTH-1:0]  z_q, z_d, at;
    logic [IT_W-1:0]         iter_q, iter_d;
    logic                    zero_q, zero_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        iter_d = iter_q;
        zero_d = zero_q;
        x_sh   = x_q >>> iter_q;
        y_sh   = y_q >>> iter_q;
        at     = PHASE_WIDTH'(atan_const(int'(iter_q), PHASE_WIDTH));
        if (load) begin
            x_d    = {{2{i_in[IQ_WIDTH-1]}}, i_in};
            y_d    = {{2{q_in[IQ_WIDTH-1]}}, q_in};
            z_d    = '0;
            iter_d = '0;
            zero_d = 1'b0;
        end else if (pre_en) begin
            // An all-zero vector would otherwise drift to a meaningless angle.
            zero_d = (x_q == '0) && (y_q == '0);
            iter_d = '0;
            if (x_q[XY_W-1]) begin
                x_d = -x_q;
                y_d = -y_q;
                // +pi and -pi share the same bit pattern in a wrapping phase word.
                z_d = {1'b1, {(PHASE_WIDTH-1){1'b0}}};
            end
        end else if (rot_en) begin
            // Rotate toward y = 0; z accumulates the angle removed.
            if (!y_q[XY_W-1]) begin
                x_d = x_q + y_sh;
                y_d = y_q - x_sh;
                z_d = z_q + at;
            end else begin
                x_d = x_q - y_sh;
                y_d = y_q + x_sh;
                z_d = z_q - at;
            end
            iter_d = iter_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            iter_q <= '0;
            zero_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            iter_q <= iter_d;
            zero_q <= zero_d;
        end
    end

    assign done      = rot_en && (iter_q == IT_W'(CORDIC_ITER - 1));
    assign magnitude = x_q;
    assign phase     = zero_q ? '0 : z_q;

endmodule

// File: rtl/iq_multi_demod.sv
// AM / FM / PM demodulator with power-of-two averaging decimator.
//   clk_in, RST       : clock, synchronous active-high reset
//   mode, dec_log2    : sampled when a sample is accepted
//   iq_valid/iq_ready : a sample transfers on a cycle where both are 1;
//                       iq_valid while iq_ready=0 drops the sample and sets overrun
//   demod_valid       : one-cycle pulse when Demodule_OUT updates (held otherwise)
//   overrun           : sticky until RST
//   dbg_state         : current FSM state
// The ACC cycle also accepts a new sample, so one sample is taken every
// CORDIC_ITER+3 cycles under continuous input.
module iq_multi_demod
    import demod_pkg::*;
#(
    parameter int IQ_WIDTH     = 12,
    parameter int OUTPUT_WIDTH = 24,
    parameter int PHASE_WIDTH  = 16,
    parameter int CORDIC_ITER  = 12,
    parameter int DEC_MAX_LOG2 = 7
) (
    input  logic                    clk_in,
    input  logic                    RST,
    input  logic [1:0]              mode,
    input  logic [3:0]              dec_log2,
    input  logic                    iq_valid,
    input  logic [IQ_WIDTH-1:0]     I_IN,
    input  logic [IQ_WIDTH-1:0]     Q_IN,
    output logic                    iq_ready,
    output logic                    demod_valid,
    output logic [OUTPUT_WIDTH-1:0] Demodule_OUT,
    output logic                    overrun,
    output logic [2:0]              dbg_state
);

    localparam int XY_W  = IQ_WIDTH + 2;
    localparam int ACC_W = OUTPUT_WIDTH + DEC_MAX_LOG2;
    localparam int CNT_W = (DEC_MAX_LOG2 > 0) ? DEC_MAX_LOG2 : 1;

    demod_state_e                   state_q, state_d;
    logic [1:0]                     mode_q, mode_d;
    logic [3:0]                     dec_q, dec_d, dec_clamped;
    logic                           first_q, first_d;
    logic                           restart_q, restart_d;
    logic [PHASE_WIDTH-1:0]         prev_phase_q, prev_phase_d, fm_diff;
    logic signed [OUTPUT_WIDTH-1:0] r_q, r_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d, base_acc, sum;
    logic [CNT_W-1:0]               cnt_q, cnt_d, base_cnt, cnt_target;
    logic [OUTPUT_WIDTH-1:0]        dout_q, dout_d;
    logic                           dvalid_q, dvalid_d;
    logic                           overrun_q, overrun_d;
    logic                           accept, cordic_done;
    logic [XY_W-1:0]                cordic_mag;
    logic [PHASE_WIDTH-1:0]         cordic_phase;

    cordic_vector_iter #(
        .IQ_WIDTH   (IQ_WIDTH),
        .PHASE_WIDTH(PHASE_WIDTH),
        .CORDIC_ITER(CORDIC_ITER)
    ) u_cordic (
        .clk_in   (clk_in),
        .rst      (RST),
        .load     (accept),
        .pre_en   (state_q == ST_PRE),
        .rot_en   (state_q == ST_ROT),
        .i_in     (I_IN),
        .q_in     (Q_IN),
        .done     (cordic_done),
        .magnitude(cordic_mag),
        .phase    (cordic_phase)
    );

    assign iq_ready    = !RST && ((state_q == ST_IDLE) || (state_q == ST_ACC));
    assign accept      = iq_valid && iq_ready;
    assign dec_clamped = (dec_log2 > 4'(DEC_MAX_LOG2)) ? 4'(DEC_MAX_LOG2) : dec_log2;
    assign fm_diff     = cordic_phase - prev_phase_q;  // modulo 2^PHASE_WIDTH
    assign cnt_target  = CNT_W'((32'd1 << dec_q) - 32'd1);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        dec_d        = dec_q;
        first_d      = first_q;
        restart_d    = restart_q;
        prev_phase_d = prev_phase_q;
        r_d          = r_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dvalid_d     = 1'b0;
        overrun_d    = overrun_q | (iq_valid & ~iq_ready);
        base_acc     = restart_q ? '0 : acc_q;
        base_cnt     = restart_q ? '0 : cnt_q;
        sum          = base_acc + {{DEC_MAX_LOG2{r_q[OUTPUT_WIDTH-1]}}, r_q};

        // Configuration travels with the sample; any change restarts averaging.
        if (accept) begin
            mode_d    = mode;
            dec_d     = dec_clamped;
            restart_d = first_q || (mode != mode_q) || (dec_clamped != dec_q);
            first_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: if (accept) state_d = ST_PRE;
            ST_PRE:  state_d = ST_ROT;
            ST_ROT:  if (cordic_done) state_d = ST_POST;
            ST_POST: begin
                case (mode_q)
                    MODE_AM: r_d = {{(OUTPUT_WIDTH-XY_W){1'b0}}, cordic_mag};
                    MODE_PM: r_d = {{(OUTPUT_WIDTH-PHASE_WIDTH){cordic_phase[PHASE_WIDTH-1]}},
                                    cordic_phase};
                    MODE_FM: r_d = {{(OUTPUT_WIDTH-PHASE_WIDTH){fm_diff[PHASE_WIDTH-1]}},
                                    fm_diff};
                    default: r_d = '0;
                endcase
                prev_phase_d = cordic_phase;
                state_d      = ST_ACC;
            end
            ST_ACC: begin
                if (restart_q && (mode_q == MODE_FM)) begin
                    // Priming sample: only prev_phase is meaningful.
                    acc_d = '0;
                    cnt_d = '0;
                end else if (base_cnt == cnt_target) begin
                    dout_d   = OUTPUT_WIDTH'(sum >>> dec_q);
                    dvalid_d = 1'b1;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = base_cnt + 1'b1;
                end
                state_d = accept ? ST_PRE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_AM;
            dec_q        <= '0;
            first_q      <= 1'b1;
            restart_q    <= 1'b0;
            prev_phase_q <= '0;
            r_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dvalid_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dec_q        <= dec_d;
            first_q      <= first_d;
            restart_q    <= restart_d;
            prev_phase_q <= prev_phase_d;
            r_q          <= r_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dvalid_q     <= dvalid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign demod_valid  = dvalid_q;
    assign Demodule_OUT = dout_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

endmodule
